// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared widths, register index type and data word type for the RISCV32 datapath
package riscv_pkg;
    localparam int XLEN   = 32;
    localparam int NREG   = 32;
    localparam int REG_AW = 5;

    typedef logic [REG_AW-1:0] reg_idx_t;
    typedef logic [XLEN-1:0]   xword_t;

    localparam reg_idx_t REG_ZERO = '0;
endpackage

// File: rtl/busy_scoreboard.sv
// rtl/busy_scoreboard.sv - pending-write bit per register with three-way hazard compare
// Optional macro WB_BYPASS_EN: the register being written back is treated as not busy.
module busy_scoreboard #(
    parameter int NREG = 32,
    parameter int AW   = 5
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_set_en,
    input  logic [AW-1:0]   i_set_idx,
    input  logic            i_clr_en,
    input  logic [AW-1:0]   i_clr_idx,
    input  logic [AW-1:0]   i_cmp_a,
    input  logic [AW-1:0]   i_cmp_b,
    input  logic [AW-1:0]   i_cmp_c,
    output logic            o_hazard,
    output logic [NREG-1:0] o_busy_mask
);
    logic [NREG-1:0] r_busy;
    logic [NREG-1:0] w_busy_next;
    logic [NREG-1:0] w_busy_eff;

    // Set is applied after clear so a same-edge issue to the written-back rd stays pending.
    always_comb begin
        w_busy_next = r_busy;
        if (i_clr_en) w_busy_next[i_clr_idx] = 1'b0;
        if (i_set_en) w_busy_next[i_set_idx] = 1'b1;
        w_busy_next[0] = 1'b0;
    end

    always_comb begin
        w_busy_eff = r_busy;
`ifdef WB_BYPASS_EN
        if (i_clr_en) w_busy_eff[i_clr_idx] = 1'b0;
`endif
        w_busy_eff[0] = 1'b0;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) r_busy <= '0;
        else       r_busy <= w_busy_next;
    end

    assign o_hazard    = w_busy_eff[i_cmp_a] | w_busy_eff[i_cmp_b] | w_busy_eff[i_cmp_c];
    assign o_busy_mask = r_busy;
endmodule

// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - integer register file with pending-write scoreboard and issue handshake
// Optional macro WB_BYPASS_EN: write-back data forwarded to reads and hazard check in the same cycle.
module regfile_scoreboard #(
    parameter int XLEN = riscv_pkg::XLEN,
    parameter int NREG = riscv_pkg::NREG,
    parameter int AW   = riscv_pkg::REG_AW
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic [AW-1:0]   i_rs1_addr,
    input  logic [AW-1:0]   i_rs2_addr,
    output logic [XLEN-1:0] o_rs1_data,
    output logic [XLEN-1:0] o_rs2_data,
    input  logic            i_iss_valid,
    input  logic [AW-1:0]   i_iss_rd,
    output logic            o_iss_ready,
    input  logic            i_wb_valid,
    input  logic [AW-1:0]   i_wb_rd,
    input  logic [XLEN-1:0] i_wb_data,
    output logic [NREG-1:0] o_busy_mask
);
    import riscv_pkg::*;

    logic [XLEN-1:0] r_regs [NREG];
    logic            w_hazard;
    logic            w_iss_fire;
    logic            w_wb_write;

    assign w_wb_write = i_wb_valid && (i_wb_rd != AW'(REG_ZERO));
    assign w_iss_fire = i_iss_valid && o_iss_ready && (i_iss_rd != AW'(REG_ZERO));
    assign o_iss_ready = !i_rst && !w_hazard;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
        end else if (w_wb_write) begin
            r_regs[i_wb_rd] <= i_wb_data;
        end
    end

    always_comb begin
        o_rs1_data = (i_rs1_addr == AW'(REG_ZERO)) ? '0 : r_regs[i_rs1_addr];
        o_rs2_data = (i_rs2_addr == AW'(REG_ZERO)) ? '0 : r_regs[i_rs2_addr];
`ifdef WB_BYPASS_EN
        if (w_wb_write && (i_rs1_addr == i_wb_rd)) o_rs1_data = i_wb_data;
        if (w_wb_write && (i_rs2_addr == i_wb_rd)) o_rs2_data = i_wb_data;
`endif
    end

    busy_scoreboard #(
        .NREG(NREG),
        .AW  (AW)
    ) u_busy (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_set_en   (w_iss_fire),
        .i_set_idx  (i_iss_rd),
        .i_clr_en   (i_wb_valid),
        .i_clr_idx  (i_wb_rd),
        .i_cmp_a    (i_rs1_addr),
        .i_cmp_b    (i_rs2_addr),
        .i_cmp_c    (i_iss_rd),
        .o_hazard   (w_hazard),
        .o_busy_mask(o_busy_mask)
    );
endmodule

// File: tb/tb_regfile_scoreboard.sv
// tb/tb_regfile_scoreboard.sv - scoreboard-driven self-checking bench for regfile_scoreboard
module tb_regfile_scoreboard;
    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  rs1_addr, rs2_addr, iss_rd, wb_rd;
    logic [31:0] rs1_data, rs2_data, wb_data;
    logic        iss_valid, iss_ready, wb_valid;
    logic [31:0] busy_mask;

    int errors = 0;
    int checks = 0;

    logic [31:0] exp_q [$];
    string       name_q [$];
    logic [31:0] e;
    string       n;

    always #5 clk = ~clk;

    regfile_scoreboard dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_rs1_addr (rs1_addr),
        .i_rs2_addr (rs2_addr),
        .o_rs1_data (rs1_data),
        .o_rs2_data (rs2_data),
        .i_iss_valid(iss_valid),
        .i_iss_rd   (iss_rd),
        .o_iss_ready(iss_ready),
        .i_wb_valid (wb_valid),
        .i_wb_rd    (wb_rd),
        .i_wb_data  (wb_data),
        .o_busy_mask(busy_mask)
    );

    // Inputs change 1 time unit after the rising edge; outputs are sampled 1 unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        iss_valid = 1'b0; iss_rd = '0; wb_valid = 1'b0; wb_rd = '0; wb_data = '0;
        rs1_addr = '0; rs2_addr = '0;
    endtask

    task automatic push(input string nm, input logic [31:0] v);
        name_q.push_back(nm);
        exp_q.push_back(v);
    endtask

    task automatic test_reset();
        idle();
        rst = 1'b1;
        step(); step();
        push("ready_in_reset", 32'd0);
        #1;
        e = exp_q.pop_front(); n = name_q.pop_front(); checks++;
        if ({31'd0, iss_ready} !== e) begin errors++; $display("FAIL %s got=%0h want=%0h", n, iss_ready, e); end
        rst = 1'b0;
        rs1_addr = 5'd3; rs2_addr = 5'd4;
        push("reset_rs1", 32'd0); push("reset_rs2", 32'd0); push("reset_busy", 32'd0); push("reset_ready", 32'd1);
        #1;
        e = exp_q.pop_front(); n = name_q.pop_front(); checks++;
        if (rs1_data !== e) begin errors++; $display("FAIL %s got=%0h want=%0h", n, rs1_data, e); end
        e = exp_q.pop_front(); n = name_q.pop_front(); checks++;
        if (rs2_data !== e) begin errors++; $display("FAIL %s got=%0h want=%0h", n, rs2_data, e); end
        e = exp_q.pop_front(); n = name_q.pop_front(); checks++;
        if (busy_mask !== e) begin errors++; $display("FAIL %s got=%0h want=%0h", n, busy_mask, e); end
        e = exp_q.pop_front(); n = name_q.pop_front(); checks++;
        if ({31'd0, iss_ready} !== e) begin errors++; $display("FAIL %s got=%0h want=%0h", n, iss_ready, e); end
    endtask

    task automatic test_writeback();
        step();
        wb_valid = 1'b1; wb_rd = 5'd1; wb_data = 32'd15;
        step();
        wb_rd = 5'd2; wb_data = 32'd4;
        step();
        idle();
        rs1_addr = 5'd1; rs2_addr = 5'd2;
        push("alu_in_a", 32'd15); push("alu_in_b", 32'd4);
        #1;
        e = exp_q.pop_front(); n = name_q.pop_front(); checks++;
        if (rs1_data !== e) begin errors++; $display("FAIL %s got=%0h want=%0h", n, rs1_data, e); end
        e = exp_q.pop_front(); n = name_q.pop_front(); checks++;
        if (rs2_data !== e) begin errors++; $display("FAIL %s got=%0h want=%0h", n, rs2_data, e); end
    endtask

    task automatic test_hazard();
        step();
        idle();
        iss_valid = 1'b1; iss_rd = 5'd5;
        push("issue5_ready", 32'd1);
        #1;
        e = exp_q.pop_front(); n = name_q.pop_front(); checks++;
        if ({31'd0, iss_ready} !== e) begin errors++; $display("FAIL %s got=%0h want=%0h", n, iss_ready, e); end
        step();
        rs1_addr = 5'd5; iss_rd = 5'd6;
        push("busy5_set", 32'h20); push("blocked_ready", 32'd0);
        #1;
        e = exp_q.pop_front(); n = name_q.pop_front(); checks++;
        if (busy_mask !== e) begin errors++; $display("FAIL %s got=%0h want=%0h", n, busy_mask, e); end
        e = exp_q.pop_front(); n = name_q.pop_front(); checks++;
        if ({31'd0, iss_ready} !== e) begin errors++; $display("FAIL %s got=%0h want=%0h", n, iss_ready, e); end
        step();
        push("held_no_state", 32'h20);
        #1;
        e = exp_q.pop_front(); n = name_q.pop_front(); checks++;
        if (busy_mask !== e) begin errors++; $display("FAIL %s got=%0h want=%0h", n, busy_mask, e); end
        wb_valid = 1'b1; wb_rd = 5'd5; wb_data = 32'hA;
`ifdef WB_BYPASS_EN
        push("wb_cycle_ready", 32'd1); push("wb_cycle_rs1", 32'hA);
`else
        push("wb_cycle_ready", 32'd0); push("wb_cycle_rs1", 32'd0);
`endif
        #1;
        e = exp_q.pop_front(); n = name_q.pop_front(); checks++;
        if ({31'd0, iss_ready} !== e) begin errors++; $display("FAIL %s got=%0h want=%0h", n, iss_ready, e); end
        e = exp_q.pop_front(); n = name_q.pop_front(); checks++;
        if (rs1_data !== e) begin errors++; $display("FAIL %s got=%0h want=%0h", n, rs1_data, e); end
        step();
        wb_valid = 1'b0;
`ifdef WB_BYPASS_EN
        push("after_wb_busy", 32'h40); push("after_wb_ready", 32'd0);
`else
        push("after_wb_busy", 32'h0); push("after_wb_ready", 32'd1);
`endif
        push("after_wb_rs1", 32'hA);
        #1;
        e = exp_q.pop_front(); n = name_q.pop_front(); checks++;
        if (busy_mask !== e) begin errors++; $display("FAIL %s got=%0h want=%0h", n, busy_mask, e); end
        e = exp_q.pop_front(); n = name_q.pop_front(); checks++;
        if ({31'd0, iss_ready} !== e) begin errors++; $display("FAIL %s got=%0h want=%0h", n, iss_ready, e); end
        e = exp_q.pop_front(); n = name_q.pop_front(); checks++;
        if (rs1_data !== e) begin errors++; $display("FAIL %s got=%0h want=%0h", n, rs1_data, e); end
        step();
        idle();
        wb_valid = 1'b1; wb_rd = 5'd6; wb_data = 32'd0;
        step();
        idle();
        push("hazard_cleanup_busy", 32'h0);
        #1;
        e = exp_q.pop_front(); n = name_q.pop_front(); checks++;
        if (busy_mask !== e) begin errors++; $display("FAIL %s got=%0h want=%0h", n, busy_mask, e); end
    endtask

    task automatic test_zero();
        step();
        wb_valid = 1'b1; wb_rd = 5'd0; wb_data = 32'hDEAD;
        iss_valid = 1'b1; iss_rd = 5'd0;
        push("x0_during_wb", 32'd0);
        #1;
        e = exp_q.pop_front(); n = name_q.pop_front(); checks++;
        if (rs1_data !== e) begin errors++; $display("FAIL %s got=%0h want=%0h", n, rs1_data, e); end
        step();
        idle();
        push("x0_read", 32'd0); push("x0_busy", 32'd0);
        #1;
        e = exp_q.pop_front(); n = name_q.pop_front(); checks++;
        if (rs1_data !== e) begin errors++; $display("FAIL %s got=%0h want=%0h", n, rs1_data, e); end
        e = exp_q.pop_front(); n = name_q.pop_front(); checks++;
        if (busy_mask !== e) begin errors++; $display("FAIL %s got=%0h want=%0h", n, busy_mask, e); end
    endtask

    task automatic test_same_edge();
        step();
        iss_valid = 1'b1; iss_rd = 5'd7;
        wb_valid = 1'b1; wb_rd = 5'd7; wb_data = 32'd9;
        step();
        idle();
        rs1_addr = 5'd7;
        push("same_edge_busy", 32'h80); push("same_edge_x7", 32'd9);
        #1;
        e = exp_q.pop_front(); n = name_q.pop_front(); checks++;
        if (busy_mask !== e) begin errors++; $display("FAIL %s got=%0h want=%0h", n, busy_mask, e); end
        e = exp_q.pop_front(); n = name_q.pop_front(); checks++;
        if (rs1_data !== e) begin errors++; $display("FAIL %s got=%0h want=%0h", n, rs1_data, e); end
        step();
        wb_valid = 1'b1; wb_rd = 5'd7; wb_data = 32'd9;
        step();
        idle();
    endtask

    task automatic test_reset_mid();
        iss_valid = 1'b1; iss_rd = 5'd5;
        step();
        idle();
        rs1_addr = 5'd1;
        push("pre_reset_busy", 32'h20); push("pre_reset_x1", 32'd15);
        #1;
        e = exp_q.pop_front(); n = name_q.pop_front(); checks++;
        if (busy_mask !== e) begin errors++; $display("FAIL %s got=%0h want=%0h", n, busy_mask, e); end
        e = exp_q.pop_front(); n = name_q.pop_front(); checks++;
        if (rs1_data !== e) begin errors++; $display("FAIL %s got=%0h want=%0h", n, rs1_data, e); end
        rst = 1'b1;
        step();
        rst = 1'b0;
        push("post_reset_busy", 32'd0); push("post_reset_x1", 32'd0);
        #1;
        e = exp_q.pop_front(); n = name_q.pop_front(); checks++;
        if (busy_mask !== e) begin errors++; $display("FAIL %s got=%0h want=%0h", n, busy_mask, e); end
        e = exp_q.pop_front(); n = name_q.pop_front(); checks++;
        if (rs1_data !== e) begin errors++; $display("FAIL %s got=%0h want=%0h", n, rs1_data, e); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] v;
        step();
        for (int i = 1; i < 32; i++) begin
            v = $urandom;
            wb_valid = 1'b1; wb_rd = 5'(i); wb_data = v;
            push($sformatf("b2b_x%0d", i), v);
            step();
        end
        idle();
        for (int i = 1; i < 32; i++) begin
            rs2_addr = 5'(i);
            #1;
            e = exp_q.pop_front(); n = name_q.pop_front(); checks++;
            if (rs2_data !== e) begin errors++; $display("FAIL %s got=%0h want=%0h", n, rs2_data, e); end
        end
        push("b2b_busy", 32'd0);
        e = exp_q.pop_front(); n = name_q.pop_front(); checks++;
        if (busy_mask !== e) begin errors++; $display("FAIL %s got=%0h want=%0h", n, busy_mask, e); end
    endtask

    initial begin
        rst = 1'b1;
        idle();
        test_reset();
        test_writeback();
        test_hazard();
        test_zero();
        test_same_edge();
        test_reset_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
